// File: rtl/cgol_row_stream.sv
// Streaming Game-of-Life engine: takes a frame row by row and emits the
// next generation row by row. A three-row window (prev, cur, incoming)
// feeds the neighbour rule. Output is a single registered stage with
// valid/ready handshaking, and a counter tracks how many frames are complete.
module cgol_row_stream #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WRAP_H = 0,
    parameter int GEN_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_row,
    output logic             out_last,
    output logic [GEN_W-1:0] gen_count
);

    localparam int RC_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam logic [RC_W-1:0] ROW_LAST = RC_W'(HEIGHT - 1);
    localparam logic [RC_W-1:0] ROW_ONE  = RC_W'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Pad a row with one ghost column at each side: the wrapped neighbour
    // when the grid is toroidal, or a dead cell otherwise.
    function automatic logic [WIDTH+1:0] pad_row(input logic [WIDTH-1:0] row);
        if (WRAP_H != 0) begin
            return {row[0], row, row[WIDTH-1]};
        end else begin
            return {1'b0, row, 1'b0};
        end
    endfunction

    // Next-generation row for the middle of three vertically adjacent rows.
    function automatic logic [WIDTH-1:0] life_rule(input logic [WIDTH-1:0] above,
                                                   input logic [WIDTH-1:0] mid,
                                                   input logic [WIDTH-1:0] below);
        logic [WIDTH+1:0] ext_a;
        logic [WIDTH+1:0] ext_m;
        logic [WIDTH+1:0] ext_b;
        logic [WIDTH-1:0] res;
        logic [3:0]       n;
        ext_a = pad_row(above);
        ext_m = pad_row(mid);
        ext_b = pad_row(below);
        res   = {WIDTH{1'b0}};
        for (int c = 0; c < WIDTH; c++) begin
            // Column c sits at ext index c+1; its neighbours are c and c+2.
            n = {3'b000, ext_a[c]} + {3'b000, ext_a[c+1]} + {3'b000, ext_a[c+2]}
              + {3'b000, ext_m[c]} + {3'b000, ext_m[c+2]}
              + {3'b000, ext_b[c]} + {3'b000, ext_b[c+1]} + {3'b000, ext_b[c+2]};
            res[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [RC_W-1:0]   row_cnt_r;
    logic [WIDTH-1:0]  prev_r;
    logic [WIDTH-1:0]  cur_r;
    logic [WIDTH-1:0]  out_row_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [GEN_W-1:0]  gen_count_r;

    logic              out_free_s;
    logic              out_beat_s;
    logic              in_ready_s;
    logic              in_beat_s;
    logic              load_s;
    logic              load_last_s;
    logic [WIDTH-1:0]  load_row_s;
    logic [WIDTH-1:0]  rule_run_s;
    logic [WIDTH-1:0]  rule_flush_s;

    assign out_free_s   = !out_valid_r || out_ready;
    assign out_beat_s   = out_valid_r && out_ready;
    assign in_beat_s    = in_valid && in_ready_s;
    assign rule_run_s   = life_rule(prev_r, cur_r, in_row);
    assign rule_flush_s = life_rule(prev_r, cur_r, {WIDTH{1'b0}});

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;
    assign out_last  = out_last_r;
    assign gen_count = gen_count_r;

    // Sequencer next state, input readiness and output-register load decision.
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        load_s      = 1'b0;
        load_last_s = 1'b0;
        load_row_s  = rule_run_s;
        case (state_r)
            ST_FILL: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RUN: begin
                in_ready_s = out_free_s;
                if (in_valid && out_free_s) begin
                    load_s     = 1'b1;
                    load_row_s = rule_run_s;
                    if (row_cnt_r == ROW_LAST) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                in_ready_s = 1'b0;
                if (out_free_s) begin
                    load_s      = 1'b1;
                    load_last_s = 1'b1;
                    load_row_s  = rule_flush_s;
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Row window and row counter; the counter folds back to zero after the
    // last row so it never leaves 0..HEIGHT-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r    <= {WIDTH{1'b0}};
            cur_r     <= {WIDTH{1'b0}};
            row_cnt_r <= {RC_W{1'b0}};
        end else if (in_beat_s) begin
            if (state_r == ST_FILL) begin
                prev_r    <= {WIDTH{1'b0}};
                cur_r     <= in_row;
                row_cnt_r <= ROW_ONE;
            end else begin
                prev_r <= cur_r;
                cur_r  <= in_row;
                if (row_cnt_r == ROW_LAST) begin
                    row_cnt_r <= {RC_W{1'b0}};
                end else begin
                    row_cnt_r <= row_cnt_r + ROW_ONE;
                end
            end
        end
    end

    // Output register: load a fresh row when free, otherwise retire on a beat
    // and hold the row steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_row_r   <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_row_r   <= load_row_s;
            out_valid_r <= 1'b1;
            out_last_r  <= load_last_s;
        end else if (out_beat_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // Generation counter: one step per delivered last row, wrapping freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            gen_count_r <= {GEN_W{1'b0}};
        end else if (out_beat_s && out_last_r) begin
            gen_count_r <= gen_count_r + {{(GEN_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_cgol_row_stream.sv
// Bench for cgol_row_stream: two 8x8 engines (dead and wrapped edges) share
// one stimulus stream and are compared each cycle against a frame-level
// Game-of-Life model; a third 16x2 wrapped engine gets a short directed run.
module tb_cgol_row_stream;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_row;
    logic        out_ready;
    logic        in_ready_n, in_ready_w;
    logic        out_valid_n, out_valid_w;
    logic [7:0]  out_row_n, out_row_w;
    logic        out_last_n, out_last_w;
    logic [15:0] gen_count_n, gen_count_w;

    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c;
    logic [15:0] in_row_c, out_row_c, gen_count_c;

    int total = 0;
    int bad   = 0;

    // model state
    logic [7:0]  frame [0:7];
    logic [7:0]  stim  [0:7];
    int          acc;
    bit          flush_p;
    bit          exp_valid;
    bit          exp_last;
    logic [7:0]  exp_row_n, exp_row_w;
    logic [15:0] exp_gen;
    logic [7:0]  log_n [$];
    logic [7:0]  log_w [$];

    cgol_row_stream #(.WIDTH(8), .HEIGHT(8), .WRAP_H(0), .GEN_W(16)) dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_row(in_row), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_row(out_row_n), .out_last(out_last_n), .gen_count(gen_count_n));

    cgol_row_stream #(.WIDTH(8), .HEIGHT(8), .WRAP_H(1), .GEN_W(16)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_row(in_row), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_row(out_row_w), .out_last(out_last_w), .gen_count(gen_count_w));

    cgol_row_stream #(.WIDTH(16), .HEIGHT(2), .WRAP_H(1), .GEN_W(16)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_row(in_row_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_row(out_row_c), .out_last(out_last_c), .gen_count(gen_count_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next generation of row k of the current frame, by direct neighbour count.
    function automatic logic [7:0] ref_next(input int k, input bit wrap);
        logic [7:0] res;
        int n, rr, cc;
        res = 8'h00;
        for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    rr = k + dr;
                    cc = c + dc;
                    if (wrap) cc = (cc + 8) % 8;
                    if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                        n += int'(frame[rr][cc]);
                end
            end
            res[c] = ((n == 3) || (frame[k][c] == 1'b1 && n == 2)) ? 1'b1 : 1'b0;
        end
        return res;
    endfunction

    // One clock cycle: drive, check the DUTs against the model, advance the model.
    task automatic cycle(input bit iv, input logic [7:0] row, input bit ordy, output bit accepted);
        bit exp_rdy, out_free, in_beat, out_beat, load, load_last;
        logic [7:0] ln, lw;
        @(negedge clk);
        in_valid  = iv;
        in_row    = row;
        out_ready = ordy;
        #1;
        out_free = !exp_valid || ordy;
        exp_rdy  = flush_p ? 1'b0 : ((acc == 0) ? 1'b1 : out_free);
        chk("in_ready_n", 32'(in_ready_n), 32'(exp_rdy));
        chk("in_ready_w", 32'(in_ready_w), 32'(exp_rdy));
        chk("out_valid_n", 32'(out_valid_n), 32'(exp_valid));
        chk("out_valid_w", 32'(out_valid_w), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_row_n", 32'(out_row_n), 32'(exp_row_n));
            chk("out_row_w", 32'(out_row_w), 32'(exp_row_w));
            chk("out_last_n", 32'(out_last_n), 32'(exp_last));
            chk("out_last_w", 32'(out_last_w), 32'(exp_last));
        end
        chk("gen_n", 32'(gen_count_n), 32'(exp_gen));
        chk("gen_w", 32'(gen_count_w), 32'(exp_gen));

        in_beat  = iv && exp_rdy;
        out_beat = exp_valid && ordy;
        if (out_beat) begin
            log_n.push_back(out_row_n);
            log_w.push_back(out_row_w);
            if (exp_last) exp_gen++;
        end
        load = 1'b0; load_last = 1'b0; ln = 8'h00; lw = 8'h00;
        if (in_beat) begin
            frame[acc] = row;
            if (acc > 0) begin
                load = 1'b1;
                ln = ref_next(acc - 1, 1'b0);
                lw = ref_next(acc - 1, 1'b1);
            end
            acc++;
            if (acc == 8) begin
                acc = 0;
                flush_p = 1'b1;
            end
        end else if (flush_p && out_free) begin
            load = 1'b1; load_last = 1'b1;
            ln = ref_next(7, 1'b0);
            lw = ref_next(7, 1'b1);
            flush_p = 1'b0;
        end
        if (load) begin
            exp_valid = 1'b1; exp_last = load_last; exp_row_n = ln; exp_row_w = lw;
        end else if (out_beat) begin
            exp_valid = 1'b0; exp_last = 1'b0;
        end
        accepted = in_beat;
    endtask

    task automatic send_rows(input int nrows, input bit rnd);
        bit ok;
        int tries;
        for (int r = 0; r < nrows; r++) begin
            ok = 1'b0;
            tries = 0;
            while (!ok && tries < 300) begin
                cycle(rnd ? ($urandom_range(0, 1) == 1) : 1'b1, stim[r],
                      rnd ? ($urandom_range(0, 9) < 3) : 1'b1, ok);
                tries++;
            end
            chk("accept_timeout", 32'(ok), 32'd1);
        end
    endtask

    task automatic drain();
        bit ok, done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle(1'b0, 8'h00, 1'b1, ok);
            done = !exp_valid && !flush_p;
        end
        chk("drain_timeout", 32'(done), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, ok);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid_c = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        acc = 0; flush_p = 1'b0; exp_valid = 1'b0; exp_last = 1'b0; exp_gen = 16'd0;
        log_n.delete(); log_w.delete();
        #1;
        chk("rst_valid_n", 32'(out_valid_n), 32'd0);
        chk("rst_valid_w", 32'(out_valid_w), 32'd0);
        chk("rst_row_n", 32'(out_row_n), 32'd0);
        chk("rst_last_n", 32'(out_last_n), 32'd0);
        chk("rst_gen_n", 32'(gen_count_n), 32'd0);
        chk("rst_valid_c", 32'(out_valid_c), 32'd0);
    endtask

    task automatic set_stim(input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4);
        for (int r = 0; r < 8; r++) stim[r] = 8'h00;
        stim[2] = r2; stim[3] = r3; stim[4] = r4;
    endtask

    initial begin
        logic [7:0] acc_or;
        reset = 1'b1; in_valid = 1'b0; in_row = 8'h00; out_ready = 1'b0;
        in_valid_c = 1'b0; in_row_c = 16'h0000; out_ready_c = 1'b1;
        acc = 0; flush_p = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
        exp_row_n = 8'h00; exp_row_w = 8'h00; exp_gen = 16'd0;
        for (int r = 0; r < 8; r++) frame[r] = 8'h00;

        // 1: vertical blinker, no backpressure
        do_reset();
        set_stim(8'h10, 8'h10, 8'h10);
        send_rows(8, 1'b0);
        drain();
        chk("t1_len", 32'(log_n.size()), 32'd8);
        chk("t1_row3", 32'(log_n[3]), 32'h38);
        chk("t1_row2", 32'(log_n[2]), 32'h00);
        chk("t1_gen", 32'(gen_count_n), 32'd1);

        // 2: edge mode
        do_reset();
        set_stim(8'h00, 8'b1000_0011, 8'h00);
        send_rows(8, 1'b0);
        drain();
        chk("t2_w_row2", 32'(log_w[2]), 32'h01);
        chk("t2_w_row3", 32'(log_w[3]), 32'h01);
        chk("t2_w_row4", 32'(log_w[4]), 32'h01);
        chk("t2_w_row5", 32'(log_w[5]), 32'h00);
        acc_or = 8'h00;
        for (int i = 0; i < log_n.size(); i++) acc_or = acc_or | log_n[i];
        chk("t2_n_allzero", 32'(acc_or), 32'h00);

        // 3: random handshakes, blinker then random contents
        do_reset();
        set_stim(8'h10, 8'h10, 8'h10);
        send_rows(8, 1'b1);
        drain();
        chk("t3_row3", 32'(log_n[3]), 32'h38);
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 8; r++) stim[r] = 8'($urandom);
            send_rows(8, 1'b1);
        end
        drain();
        chk("t3_gen", 32'(gen_count_n), 32'd4);

        // 4: back-to-back blinker frames with no idle cycles
        do_reset();
        set_stim(8'h10, 8'h10, 8'h10);
        send_rows(8, 1'b0);
        set_stim(8'h00, 8'h38, 8'h00);
        send_rows(8, 1'b0);
        set_stim(8'h10, 8'h10, 8'h10);
        send_rows(8, 1'b0);
        drain();
        chk("t4_gen", 32'(gen_count_n), 32'd3);
        chk("t4_f0_row3", 32'(log_n[3]), 32'h38);
        chk("t4_f1_row2", 32'(log_n[10]), 32'h10);
        chk("t4_f1_row4", 32'(log_n[12]), 32'h10);
        chk("t4_f2_row3", 32'(log_n[19]), 32'h38);

        // 5: reset after row 4, then a full frame
        do_reset();
        set_stim(8'h10, 8'h10, 8'h10);
        send_rows(5, 1'b0);
        do_reset();
        send_rows(8, 1'b0);
        drain();
        chk("t5_len", 32'(log_n.size()), 32'd8);
        chk("t5_gen", 32'(gen_count_n), 32'd1);
        chk("t5_row3", 32'(log_n[3]), 32'h38);

        // 6: 16-wide, 2-tall wrapped grid, all cells live
        do_reset();
        @(negedge clk);
        in_valid_c = 1'b1; in_row_c = 16'hFFFF; out_ready_c = 1'b1;
        #1 chk("t6_rdy0", 32'(in_ready_c), 32'd1);
        @(negedge clk);
        #1 chk("t6_rdy1", 32'(in_ready_c), 32'd1);
        @(negedge clk);
        in_valid_c = 1'b0;
        #1;
        chk("t6_v0", 32'(out_valid_c), 32'd1);
        chk("t6_row0", 32'(out_row_c), 32'h0000);
        chk("t6_last0", 32'(out_last_c), 32'd0);
        chk("t6_flush_rdy", 32'(in_ready_c), 32'd0);
        @(negedge clk);
        #1;
        chk("t6_v1", 32'(out_valid_c), 32'd1);
        chk("t6_row1", 32'(out_row_c), 32'h0000);
        chk("t6_last1", 32'(out_last_c), 32'd1);
        @(negedge clk);
        #1;
        chk("t6_idle", 32'(out_valid_c), 32'd0);
        chk("t6_gen", 32'(gen_count_c), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
